// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and the parity helper for the PS/2 key sender.
// PS2_SENDER_EXT_EN adds the E0-prefix state for extended keys.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

`ifdef PS2_SENDER_EXT_EN
    typedef enum logic [1:0] {
        KS_IDLE       = 2'd0,
        KS_PREFIX_EXT = 2'd1,
        KS_PREFIX_BRK = 2'd2,
        KS_CODE       = 2'd3
    } key_state_t;
`else
    typedef enum logic [1:0] {
        KS_IDLE       = 2'd0,
        KS_PREFIX_BRK = 2'd2,
        KS_CODE       = 2'd3
    } key_state_t;
`endif

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_BIT_HI = 2'd1,
        SER_BIT_LO = 2'd2,
        SER_GAP    = 2'd3
    } ser_state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Serialises one byte as an 11-bit PS/2 device frame followed by an idle gap.
// A start in the last gap cycle chains the next frame with no extra idle cycle.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rest,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_dat,
    output ser_state_t state
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       BIT_LAST = 4'(PS2_FRAME_BITS - 1);

    ser_state_t       state_n;
    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic [3:0]       bit_idx, bit_idx_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [10:0]      frame, frame_n;
    logic             load;

    always_ff @(posedge clk) begin
        if (rest) begin
            state   <= SER_IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
            frame   <= '1;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_idx <= bit_idx_n;
            gap_cnt <= gap_cnt_n;
            frame   <= frame_n;
        end
    end

    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        bit_idx_n = bit_idx;
        gap_cnt_n = gap_cnt;
        frame_n   = frame;
        done      = 1'b0;
        load      = 1'b0;
        case (state)
            SER_IDLE: load = start;
            SER_BIT_HI: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    state_n   = SER_BIT_LO;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            SER_BIT_LO: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        gap_cnt_n = '0;
                        state_n   = SER_GAP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        state_n   = SER_BIT_HI;
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            SER_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    done    = 1'b1;
                    state_n = SER_IDLE;
                    load    = start;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = SER_IDLE;
        endcase
        // Frame bit 0 is the start bit; the index walks upward, so data goes out LSB first.
        if (load) begin
            state_n   = SER_BIT_HI;
            div_cnt_n = '0;
            bit_idx_n = '0;
            frame_n   = {1'b1, odd_parity(data), data, 1'b0};
        end
    end

    assign ps2_clk = (state != SER_BIT_LO);
    assign ps2_dat = (state == SER_BIT_HI || state == SER_BIT_LO) ? frame[bit_idx] : 1'b1;

endmodule

// File: rtl/ps2_key_sender.sv
// Key-event sequencer: emits [E0] [F0] code frames through ps2_frame_tx.
// The E0 prefix and key_ext port exist only when PS2_SENDER_EXT_EN is defined.
module ps2_key_sender
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rest,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_release,
`ifdef PS2_SENDER_EXT_EN
    input  logic       key_ext,
`endif
    output logic       key_ready,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_dat
);

    // Handshake: an event is taken on any rising edge where key_valid && key_ready;
    // key_valid while key_ready is low is dropped, never queued.
    key_state_t state, state_n;
    ser_state_t ser_state;
    logic [7:0] code_q;
    logic       accept;
    logic       ser_start;
    logic       ser_done;
    logic [7:0] ser_byte;
`ifdef PS2_SENDER_EXT_EN
    logic       release_q;
`endif

    always_ff @(posedge clk) begin
        if (rest) begin
            state     <= KS_IDLE;
            code_q    <= '0;
`ifdef PS2_SENDER_EXT_EN
            release_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                code_q    <= key_code;
`ifdef PS2_SENDER_EXT_EN
                release_q <= key_release;
`endif
            end
        end
    end

    assign accept = key_valid && (state == KS_IDLE);

    always_comb begin
        state_n = state;
        case (state)
            KS_IDLE: begin
                if (accept) begin
`ifdef PS2_SENDER_EXT_EN
                    if (key_ext)          state_n = KS_PREFIX_EXT;
                    else if (key_release) state_n = KS_PREFIX_BRK;
                    else                  state_n = KS_CODE;
`else
                    state_n = key_release ? KS_PREFIX_BRK : KS_CODE;
`endif
                end
            end
`ifdef PS2_SENDER_EXT_EN
            KS_PREFIX_EXT: if (ser_done) state_n = release_q ? KS_PREFIX_BRK : KS_CODE;
`endif
            KS_PREFIX_BRK: if (ser_done) state_n = KS_CODE;
            KS_CODE:       if (ser_done) state_n = KS_IDLE;
            default:       state_n = KS_IDLE;
        endcase
    end

    // The byte follows the state being entered so the next frame launches in the
    // same cycle the previous one reports done, keeping frames back to back.
    always_comb begin
        case (state_n)
`ifdef PS2_SENDER_EXT_EN
            KS_PREFIX_EXT: ser_byte = PS2_EXT_CODE;
`endif
            KS_PREFIX_BRK: ser_byte = PS2_BREAK_CODE;
            default:       ser_byte = code_q;
        endcase
    end

    assign ser_start = (state != KS_IDLE) && (state_n != KS_IDLE) &&
                       ((ser_state == SER_IDLE) || ser_done);

    ps2_frame_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_frame_tx (
        .clk     (clk),
        .rest    (rest),
        .start   (ser_start),
        .data    (ser_byte),
        .done    (ser_done),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .state   (ser_state)
    );

    assign key_ready = (state == KS_IDLE);
    assign busy      = ~key_ready;

endmodule

// File: tb/tb_ps2_key_sender.sv
// Directed bench for ps2_key_sender with CLK_DIV=4, GAP_CYCLES=8 (96-cycle frames).
// Define PS2_SENDER_EXT_EN to also run the extended-break sequence.
module tb_ps2_key_sender;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rest = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_release = 1'b0;
`ifdef PS2_SENDER_EXT_EN
    logic       key_ext = 1'b0;
`endif
    logic       key_ready;
    logic       busy;
    logic       ps2_clk;
    logic       ps2_dat;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];
    logic [10:0] rx_shift = '0;
    logic [3:0]  rx_cnt = '0;
    logic        prev_clk = 1'b1;
    logic [10:0] last_frame = '0;

    ps2_key_sender #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rest        (rest),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_release (key_release),
`ifdef PS2_SENDER_EXT_EN
        .key_ext     (key_ext),
`endif
        .key_ready   (key_ready),
        .busy        (busy),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // host-side receiver: sample data on each falling ps2_clk, observed at negedge clk
    always @(negedge clk) begin
        if (rest) begin
            rx_cnt = '0;
        end else if (prev_clk && !ps2_clk) begin
            rx_shift[rx_cnt] = ps2_dat;
            if (rx_cnt == 4'd10) begin
                got_q.push_back(rx_shift);
                rx_cnt = '0;
            end else begin
                rx_cnt = rx_cnt + 4'd1;
            end
        end
        prev_clk = ps2_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic accept_event(input logic [7:0] code, input logic rel, input logic ext);
        int guard = 0;
        while (!key_ready && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("ready_before_accept", 32'(key_ready), 32'd1);
        key_code    = code;
        key_release = rel;
`ifdef PS2_SENDER_EXT_EN
        key_ext     = ext;
`else
        if (ext) $display("note: ext request ignored in this build");
`endif
        key_valid   = 1'b1;
        @(posedge clk); #1;
        key_valid   = 1'b0;
    endtask

    task automatic send_event(input logic [7:0] code, input logic rel, input logic ext,
                              input int exp_lat, input int glitch_at, input string tag);
        int cycles = 0;
        int first_fall = 0;
        accept_event(code, rel, ext);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        while (!key_ready && cycles < 2000) begin
            if (cycles == glitch_at) begin
                key_code  = 8'h32;
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) begin
                check_eq({tag, "_start_dat"}, 32'(ps2_dat), 32'd0);
                check_eq({tag, "_start_clk"}, 32'(ps2_clk), 32'd1);
            end
            if (first_fall == 0 && !ps2_clk) first_fall = cycles;
        end
        key_valid = 1'b0;
        check_eq({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        check_eq({tag, "_first_fall"}, 32'(first_fall), 32'(1 + CLK_DIV));
    endtask

    // scoreboard
    task automatic check_frames(input string tag);
        logic [10:0] e;
        logic [10:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check_eq({tag, "_frame_missing"}, 32'h0, 32'(e));
            end else begin
                g = got_q.pop_front();
                last_frame = g;
                check_eq({tag, "_frame"}, 32'(g), 32'(e));
            end
        end
        check_eq({tag, "_extra_frames"}, 32'(got_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(key_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ps2_clk", 32'(ps2_clk), 32'd1);
        check_eq("rst_ps2_dat", 32'(ps2_dat), 32'd1);
        rest = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // make 1C: stop=1 parity=0 data=1C start=0
        exp_q.push_back(11'h438);
        send_event(8'h1C, 1'b0, 1'b0, 97, -1, "make_1c");
        check_frames("make_1c");

        // break 1C: F0 (parity 1) then 1C
        exp_q.push_back(11'h7E0);
        exp_q.push_back(11'h438);
        send_event(8'h1C, 1'b1, 1'b0, 193, -1, "break_1c");
        check_frames("break_1c");

        // code 00 and FF both carry parity 1
        exp_q.push_back(11'h600);
        send_event(8'h00, 1'b0, 1'b0, 97, -1, "make_00");
        check_frames("make_00");
        check_eq("c00_start", 32'(last_frame[0]), 32'd0);
        check_eq("c00_parity", 32'(last_frame[9]), 32'd1);
        check_eq("c00_stop", 32'(last_frame[10]), 32'd1);

        exp_q.push_back(11'h7FE);
        send_event(8'hFF, 1'b0, 1'b0, 97, -1, "make_ff");
        check_frames("make_ff");
        check_eq("cff_start", 32'(last_frame[0]), 32'd0);
        check_eq("cff_parity", 32'(last_frame[9]), 32'd1);
        check_eq("cff_stop", 32'(last_frame[10]), 32'd1);

        // key_valid with 32 mid-frame must be dropped
        exp_q.push_back(11'h438);
        send_event(8'h1C, 1'b0, 1'b0, 97, 30, "ignore_32");
        repeat (150) @(posedge clk);
        #1;
        check_eq("ignore_32_ready", 32'(key_ready), 32'd1);
        check_frames("ignore_32");

        // reset during bit 5, then a clean make 24
        begin
            int guard = 0;
            accept_event(8'h1C, 1'b0, 1'b0);
            while (rx_cnt != 4'd5 && guard < 500) begin
                @(posedge clk); #1;
                guard++;
            end
            check_eq("abort_reached_bit5", 32'(rx_cnt), 32'd5);
            rest = 1'b1;
            @(posedge clk); #1;
            check_eq("abort_ps2_clk", 32'(ps2_clk), 32'd1);
            check_eq("abort_ps2_dat", 32'(ps2_dat), 32'd1);
            check_eq("abort_ready", 32'(key_ready), 32'd1);
            check_eq("abort_busy", 32'(busy), 32'd0);
            rest = 1'b0;
            @(posedge clk); #1;
            check_eq("abort_no_frame", 32'(got_q.size()), 32'd0);
        end
        exp_q.push_back(11'h648);
        send_event(8'h24, 1'b0, 1'b0, 97, -1, "make_24");
        check_frames("make_24");

`ifdef PS2_SENDER_EXT_EN
        // extended break 74: E0, F0, 74
        exp_q.push_back(11'h5C0);
        exp_q.push_back(11'h7E0);
        exp_q.push_back(11'h6E8);
        send_event(8'h74, 1'b1, 1'b1, 289, -1, "ext_break_74");
        check_frames("ext_break_74");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_sender.md
# ps2_key_sender

PS/2 device-side transmitter: turns key events (scan code plus make/break flag) into PS/2 frames on open-collector-style `ps2_clk`/`ps2_dat` outputs, the way a keyboard does. It is the other end of the PS/2 keyboard receive path. It drives the receiver in simulation and on-board loopback, and stands in for a physical keyboard. Break events are emitted as an `F0` prefix frame followed by the code frame.

## Interface
Parameters:
- `CLK_DIV`, default 50: system clocks per PS/2 clock half-period (≥2).
- `GAP_CYCLES`, default 200: idle system clocks after every frame (≥1).

Ports:
- `clk`, input, 1: system clock. One clock domain only.
- `rest`, input, 1: reset. Synchronous and active-high.
- `key_valid`, input, 1: event request.
- `key_code`, input, 8: scan code. Sampled on accept.
- `key_release`, input, 1: 1 = break event, 0 = make event. Sampled on accept.
- `key_ext`, input, 1: extended key. Present only with `PS2_SENDER_EXT_EN`.
- `key_ready`, output, 1: block can accept an event.
- `busy`, output, 1: a sequence is in progress. Equals `~key_ready`.
- `ps2_clk`, output, 1: PS/2 clock. Idles at 1.
- `ps2_dat`, output, 1: PS/2 data. Idles at 1.

## Operation
- Reset values: `key_ready`=1, `busy`=0, `ps2_clk`=1, `ps2_dat`=1. Reset also clears the FSM, counters and the captured event.
- Accept: on a rising edge where `key_valid && key_ready`.
  - The code and flags are captured and `key_ready` drops.
  - `key_valid` while `key_ready`=0 is ignored. It is neither queued nor captured.
- Byte sequence per event:
  - Optional `E0` (only when extended is compiled in and `key_ext`=1).
  - Then `F0` if `key_release`=1.
  - Then `key_code`.
- Frame: 11 bits in this order:
  - Start bit 0.
  - 8 data bits, LSB first.
  - Odd parity bit = `~^byte`.
  - Stop bit 1.
- Top FSM states: IDLE → (PREFIX_EXT) → (PREFIX_BRK) → CODE → IDLE. Each non-IDLE state hands one byte to the frame serialiser and waits for its `done`.
- Serialiser FSM states: IDLE → BIT_HI → BIT_LO → (repeat for 11 bits) → GAP → IDLE.
  - BIT_HI: `ps2_dat` = current bit, `ps2_clk`=1, for `CLK_DIV` cycles.
  - BIT_LO: `ps2_clk`=0, `ps2_dat` held, for `CLK_DIV` cycles.
  - GAP: both lines 1 for `GAP_CYCLES` cycles, then `done` pulses for 1 cycle.
- `ps2_dat` changes only while `ps2_clk`=1. The receiver samples on the falling edge of `ps2_clk`.
- Widths:
  - Divider counter is `$clog2(CLK_DIV)` bits and wraps to 0 at `CLK_DIV-1`.
  - Bit index is 4 bits and counts 0..10.
  - Gap counter is `$clog2(GAP_CYCLES+1)` bits.
- Reset mid-frame: at the next edge the frame is aborted, both lines return to 1, and `key_ready`=1. No partial frame is resumed.
- Code `F0` or `E0` supplied as `key_code` is sent verbatim, without special handling.

## Timing
- Accept at edge N. At edge N+1 the start bit is on the line: `ps2_dat`=0, `ps2_clk`=1.
- First falling edge of `ps2_clk` at N+1+`CLK_DIV`.
- One frame occupies 22·`CLK_DIV` + `GAP_CYCLES` cycles.
- Event latency from accept to `key_ready`=1: k·(22·`CLK_DIV` + `GAP_CYCLES`) + 1 cycles, where k = number of frames (1–3).
- Consecutive frames of one event follow back to back. Each is separated only by its own GAP.
- An event can be accepted on the same cycle `key_ready` rises.

## Configuration
- `PS2_SENDER_EXT_EN` defined:
  - `key_ext` port exists.
  - PREFIX_EXT state emits `E0` before any `F0`.
- Not defined:
  - No `key_ext` port and no PREFIX_EXT state.
  - Sequences are `code` or `F0 code` only.

## Structure
- Package `ps2_pkg`:
  - `PS2_BREAK_CODE`=8'hF0.
  - `PS2_EXT_CODE`=8'hE0.
  - `PS2_FRAME_BITS`=11.
  - Top and serialiser state enums.
  - Odd-parity function.
- Sub-module `ps2_frame_tx`: takes one byte with `start`/`done` handshake and owns the divider, bit index and gap. `ps2_key_sender` holds the sequencing FSM only.

## Test plan
All scenarios use `CLK_DIV`=4 and `GAP_CYCLES`=8, so one frame is 96 cycles.
- Make `1C` → one frame; bits on falling edges 0,0,0,1,1,1,0,0,0,0,1 (parity 0); `key_ready` returns after 97 cycles. The PS/2 receiver decodes `1C`.
- Break `1C` → frames `F0` (parity 1) then `1C`; 193 cycles; the receiver sees `F0`, `1C`.
- Code `00` → parity bit 1. Code `FF` → parity bit 1. Check stop bit = 1 and start bit = 0 in both.
- `key_valid` pulsed with code `32` mid-frame of a `1C` event → ignored; only `1C` appears on the line.
- `rest` asserted at bit 5 of a frame → next edge `ps2_clk`=`ps2_dat`=1, `key_ready`=1. A new make `24` afterwards sends a clean frame.
- With `PS2_SENDER_EXT_EN`, break extended `74` → `E0`, `F0`, `74`; 289 cycles to ready.
